// File: rtl/assoc_cache_controller.sv
// 2-way set-associative, write-back, write-allocate cache controller with one LRU bit per set.
// Defining CACHE_FLUSH_EN builds the FLUSH state that writes back every dirty line on cache_flush.
module assoc_cache_controller #(
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned WORDS_PER_LINE = 4,
   parameter int unsigned NUM_SETS       = 256,
   parameter int unsigned ADDR_W         = 32,
   localparam int unsigned LINE_W        = DATA_W * WORDS_PER_LINE
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              read_req,
   input  logic              write_req,
   input  logic              cache_flush,
   input  logic [ADDR_W-1:0] p_addr,
   input  logic [DATA_W-1:0] p_w_data,
   output logic [DATA_W-1:0] p_r_data,
   output logic              stall,
   output logic [ADDR_W-1:0] m_addr,
   output logic [LINE_W-1:0] m_w_data,
   input  logic [LINE_W-1:0] m_r_data,
   output logic              mem_read,
   output logic              mem_write,
   input  logic              main_mem_ack
);

   localparam int unsigned BoW  = $clog2(DATA_W / 8);
   localparam int unsigned WoW  = $clog2(WORDS_PER_LINE);
   localparam int unsigned IdxW = $clog2(NUM_SETS);
   localparam int unsigned OffW = BoW + WoW;
   localparam int unsigned TagW = ADDR_W - OffW - IdxW;

   typedef enum logic [2:0] {
      StIdle,
      StCompare,
      StWriteBack,
      StAllocate
`ifdef CACHE_FLUSH_EN
      , StFlush
`endif
   } state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q, rdata_q;
   logic                wr_q;
   logic                victim_q, victim_d;
   logic [NUM_SETS-1:0] valid_q [2];
   logic [NUM_SETS-1:0] dirty_q [2];
   logic [NUM_SETS-1:0] lru_q;
   logic [TagW-1:0]     tag_q  [2][NUM_SETS];
   logic [LINE_W-1:0]   data_q [2][NUM_SETS];

   logic [IdxW-1:0]     req_idx;
   logic [TagW-1:0]     req_tag;
   logic [WoW-1:0]      req_word;
   logic                hit0, hit1, hit_way, miss_way;
   logic                latch_req, hit_upd, alloc_upd;
   logic                unused_addr;

   assign req_idx     = addr_q[OffW +: IdxW];
   assign req_tag     = addr_q[ADDR_W-1 -: TagW];
   assign req_word    = addr_q[BoW +: WoW];
   assign unused_addr = ^addr_q[BoW-1:0];
   assign hit0        = valid_q[0][req_idx] && (tag_q[0][req_idx] == req_tag);
   assign hit1        = valid_q[1][req_idx] && (tag_q[1][req_idx] == req_tag);
   assign hit_way     = ~hit0;
   assign p_r_data    = rdata_q;

   // Fill an empty way first (way 0 before way 1); only evict the LRU way when the set is full.
   always_comb begin
      if (!valid_q[0][req_idx])      miss_way = 1'b0;
      else if (!valid_q[1][req_idx]) miss_way = 1'b1;
      else                           miss_way = lru_q[req_idx];
   end

`ifdef CACHE_FLUSH_EN
   // Walk index is {set, way} so way 0 of a set is visited before way 1.
   logic [IdxW:0]   walk_q, walk_d;
   logic [IdxW-1:0] walk_set;
   logic            walk_way, walk_dirty, flush_clear;

   assign walk_way   = walk_q[0];
   assign walk_set   = walk_q[IdxW:1];
   assign walk_dirty = valid_q[walk_way][walk_set] && dirty_q[walk_way][walk_set];
`else
   logic unused_flush;
   assign unused_flush = cache_flush;
`endif

   always_comb begin
      state_d   = state_q;
      victim_d  = victim_q;
      stall     = 1'b1;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      m_addr    = '0;
      m_w_data  = '0;
      latch_req = 1'b0;
      hit_upd   = 1'b0;
      alloc_upd = 1'b0;
`ifdef CACHE_FLUSH_EN
      walk_d      = walk_q;
      flush_clear = 1'b0;
`endif
      unique case (state_q)
         StIdle: begin
            stall = 1'b0;
`ifdef CACHE_FLUSH_EN
            if (cache_flush) state_d = StFlush;
            else
`endif
            if (write_req || read_req) begin
               latch_req = 1'b1;
               state_d   = StCompare;
            end
         end
         StCompare: begin
            if (hit0 || hit1) begin
               hit_upd = 1'b1;
               state_d = StIdle;
            end else begin
               victim_d = miss_way;
               state_d  = (valid_q[miss_way][req_idx] && dirty_q[miss_way][req_idx]) ?
                          StWriteBack : StAllocate;
            end
         end
         StWriteBack: begin
            mem_write = 1'b1;
            m_addr    = {tag_q[victim_q][req_idx], req_idx, {OffW{1'b0}}};
            m_w_data  = data_q[victim_q][req_idx];
            if (main_mem_ack) state_d = StAllocate;
         end
         StAllocate: begin
            mem_read = 1'b1;
            m_addr   = {addr_q[ADDR_W-1:OffW], {OffW{1'b0}}};
            if (main_mem_ack) begin
               alloc_upd = 1'b1;
               state_d   = StCompare;
            end
         end
`ifdef CACHE_FLUSH_EN
         StFlush: begin
            if (walk_dirty) begin
               mem_write = 1'b1;
               m_addr    = {tag_q[walk_way][walk_set], walk_set, {OffW{1'b0}}};
               m_w_data  = data_q[walk_way][walk_set];
            end
            if (!walk_dirty || main_mem_ack) begin
               walk_d = walk_q + {{IdxW{1'b0}}, 1'b1};
               if (&walk_q) begin
                  flush_clear = 1'b1;
                  state_d     = StIdle;
               end
            end
         end
`endif
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         addr_q     <= '0;
         wdata_q    <= '0;
         wr_q       <= 1'b0;
         rdata_q    <= '0;
         victim_q   <= 1'b0;
         valid_q[0] <= '0;
         valid_q[1] <= '0;
         dirty_q[0] <= '0;
         dirty_q[1] <= '0;
         lru_q      <= '0;
`ifdef CACHE_FLUSH_EN
         walk_q     <= '0;
`endif
      end else begin
         state_q  <= state_d;
         victim_q <= victim_d;
         if (latch_req) begin
            addr_q  <= p_addr;
            wdata_q <= p_w_data;
            wr_q    <= write_req;
         end
         if (hit_upd) begin
            lru_q[req_idx] <= ~hit_way;
            if (wr_q) dirty_q[hit_way][req_idx] <= 1'b1;
            else      rdata_q <= data_q[hit_way][req_idx][req_word*DATA_W +: DATA_W];
         end
         if (alloc_upd) begin
            valid_q[victim_q][req_idx] <= 1'b1;
            dirty_q[victim_q][req_idx] <= 1'b0;
         end
`ifdef CACHE_FLUSH_EN
         walk_q <= walk_d;
         if (flush_clear) begin
            valid_q[0] <= '0;
            valid_q[1] <= '0;
            dirty_q[0] <= '0;
            dirty_q[1] <= '0;
            lru_q      <= '0;
         end
`endif
      end
   end

   // Line storage is deliberately not reset; valid bits gate every use.
   always_ff @(posedge clk) begin
      if (hit_upd && wr_q) data_q[hit_way][req_idx][req_word*DATA_W +: DATA_W] <= wdata_q;
      if (alloc_upd) begin
         data_q[victim_q][req_idx] <= m_r_data;
         tag_q[victim_q][req_idx]  <= req_tag;
      end
   end

endmodule

// File: tb/tb_assoc_cache_controller.sv
// Directed self-checking bench for assoc_cache_controller at default parameters.
// Covers miss fill, write hit, LRU eviction with write-back, request priority and mid-transfer reset.
`timescale 1ns/1ps
module tb_assoc_cache_controller;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned LW = 128;

   localparam logic [LW-1:0] LINE_A  = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'hDEAD_BEEF};
   localparam logic [LW-1:0] LINE_AD = {32'h4444_4444, 32'h3333_3333, 32'h1234_5678, 32'hDEAD_BEEF};
   localparam logic [LW-1:0] LINE_B  = {32'hB0B0_0004, 32'hB0B0_0003, 32'hB0B0_0002, 32'hB0B0_0001};
   localparam logic [LW-1:0] LINE_C  = {32'hC0C0_0004, 32'hC0C0_0003, 32'hC0C0_0002, 32'hC0C0_0001};
   localparam logic [LW-1:0] LINE_D  = {32'hD0D0_0004, 32'hD0D0_0003, 32'hD0D0_0002, 32'hD0D0_0001};
   localparam logic [LW-1:0] LINE_DW = {32'hD0D0_0004, 32'h5555_AAAA, 32'hD0D0_0002, 32'hD0D0_0001};

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          read_req = 1'b0, write_req = 1'b0, cache_flush = 1'b0, main_mem_ack = 1'b0;
   logic [AW-1:0] p_addr = '0;
   logic [DW-1:0] p_w_data = '0;
   logic [DW-1:0] p_r_data;
   logic          stall;
   logic [AW-1:0] m_addr;
   logic [LW-1:0] m_w_data;
   logic [LW-1:0] m_r_data = '0;
   logic          mem_read, mem_write;

   int checks = 0;
   int errors = 0;
   int rd_cnt = 0, wr_cnt = 0, both_cnt = 0;

   assoc_cache_controller dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .read_req     (read_req),
      .write_req    (write_req),
      .cache_flush  (cache_flush),
      .p_addr       (p_addr),
      .p_w_data     (p_w_data),
      .p_r_data     (p_r_data),
      .stall        (stall),
      .m_addr       (m_addr),
      .m_w_data     (m_w_data),
      .m_r_data     (m_r_data),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .main_mem_ack (main_mem_ack)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_read) rd_cnt <= rd_cnt + 1;
      if (mem_write) wr_cnt <= wr_cnt + 1;
      if (mem_read && mem_write) both_cnt <= both_cnt + 1;
   end

   task automatic start_req(input bit rd, input bit wr, input logic [AW-1:0] a,
                            input logic [DW-1:0] d);
      @(negedge clk);
      read_req = rd; write_req = wr; p_addr = a; p_w_data = d;
      @(negedge clk);
      read_req = 1'b0; write_req = 1'b0;
   endtask

   task automatic wait_mem(input bit want_wr, output bit ok);
      int i = 0;
      while (!(want_wr ? mem_write : mem_read) && i < 1200) begin
         @(negedge clk);
         i++;
      end
      ok = want_wr ? mem_write : mem_read;
   endtask

   task automatic ack(input logic [LW-1:0] line);
      main_mem_ack = 1'b1; m_r_data = line;
      @(negedge clk);
      main_mem_ack = 1'b0;
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (stall && n < 20) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall); end
      checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL reset_mem_read got=%b exp=0", mem_read); end
      checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL reset_mem_write got=%b exp=0", mem_write); end
      checks++; if (p_r_data !== 32'h0) begin errors++; $display("FAIL reset_p_r_data got=%h exp=0", p_r_data); end
      checks++; if (m_addr !== 32'h0) begin errors++; $display("FAIL reset_m_addr got=%h exp=0", m_addr); end
      checks++; if (m_w_data !== '0) begin errors++; $display("FAIL reset_m_w_data got=%h exp=0", m_w_data); end
      rst_n = 1'b1;
   endtask

   task automatic test_read_miss;
      bit ok; int n; int wr0;
      wr0 = wr_cnt;
      start_req(1'b1, 1'b0, 32'hABCD_0000, '0);
      wait_mem(1'b0, ok);
      checks++; if (!ok) begin errors++; $display("FAIL miss_mem_read got=%b exp=1", mem_read); end
      checks++; if (m_addr !== 32'hABCD_0000) begin errors++; $display("FAIL miss_m_addr got=%h exp=abcd0000", m_addr); end
      ack(LINE_A);
      wait_idle(n);
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL miss_stall_fall got=%b exp=0", stall); end
      checks++; if (p_r_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL miss_p_r_data got=%h exp=deadbeef", p_r_data); end
      checks++; if (wr_cnt != wr0) begin errors++; $display("FAIL miss_no_write got=%0d exp=0 write cycles", wr_cnt - wr0); end
   endtask

   task automatic test_write_hit;
      int n; int rd0; int wr0;
      rd0 = rd_cnt; wr0 = wr_cnt;
      start_req(1'b0, 1'b1, 32'hABCD_0004, 32'h1234_5678);
      wait_idle(n);
      checks++; if (n != 1) begin errors++; $display("FAIL wr_hit_stall_cycles got=%0d exp=1", n); end
      checks++; if ((rd_cnt - rd0) + (wr_cnt - wr0) != 0) begin errors++; $display("FAIL wr_hit_traffic got=%0d exp=0", (rd_cnt - rd0) + (wr_cnt - wr0)); end
      checks++; if (p_r_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_hit_p_r_hold got=%h exp=deadbeef", p_r_data); end
      start_req(1'b1, 1'b0, 32'hABCD_0004, '0);
      wait_idle(n);
      checks++; if (n != 1) begin errors++; $display("FAIL rd_hit_stall_cycles got=%0d exp=1", n); end
      checks++; if (p_r_data !== 32'h1234_5678) begin errors++; $display("FAIL rd_hit_data got=%h exp=12345678", p_r_data); end
   endtask

   task automatic test_lru_evict;
      bit ok; int n; int wr0;
      start_req(1'b1, 1'b0, 32'h2AF3_4000, '0);
      wait_mem(1'b0, ok);
      checks++; if (!ok || m_addr !== 32'h2AF3_4000) begin errors++; $display("FAIL fill_b_addr got=%h exp=2af34000", m_addr); end
      ack(LINE_B);
      wait_idle(n);
      checks++; if (p_r_data !== 32'hB0B0_0001) begin errors++; $display("FAIL fill_b_data got=%h exp=b0b00001", p_r_data); end
      start_req(1'b1, 1'b0, 32'hABCD_0000, '0);
      wait_idle(n);
      checks++; if (n != 1 || p_r_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL reread_a got=%h/%0d exp=deadbeef/1", p_r_data, n); end
      wr0 = wr_cnt;
      start_req(1'b1, 1'b0, 32'h1111_1000, '0);
      wait_mem(1'b0, ok);
      checks++; if (!ok || m_addr !== 32'h1111_1000) begin errors++; $display("FAIL fill_c_addr got=%h exp=11111000", m_addr); end
      ack(LINE_C);
      wait_idle(n);
      checks++; if (wr_cnt != wr0) begin errors++; $display("FAIL clean_victim_write got=%0d exp=0", wr_cnt - wr0); end
      checks++; if (p_r_data !== 32'hC0C0_0001) begin errors++; $display("FAIL fill_c_data got=%h exp=c0c00001", p_r_data); end
      start_req(1'b1, 1'b0, 32'h2AF3_4000, '0);
      wait_mem(1'b1, ok);
      checks++; if (!ok || m_addr !== 32'hABCD_0000) begin errors++; $display("FAIL wb_addr got=%h exp=abcd0000", m_addr); end
      checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL wb_mem_read got=%b exp=0", mem_read); end
      checks++; if (m_w_data !== LINE_AD) begin errors++; $display("FAIL wb_data got=%h exp=%h", m_w_data, LINE_AD); end
      ack('0);
      wait_mem(1'b0, ok);
      checks++; if (!ok || m_addr !== 32'h2AF3_4000) begin errors++; $display("FAIL refill_b_addr got=%h exp=2af34000", m_addr); end
      ack(LINE_B);
      wait_idle(n);
      checks++; if (p_r_data !== 32'hB0B0_0001) begin errors++; $display("FAIL refill_b_data got=%h exp=b0b00001", p_r_data); end
   endtask

   // Leaves a write-back of the 0xABCD_0000 line pending for test_reset_mid_transfer.
   task automatic test_rw_priority;
      bit ok; int n; int wr0;
      start_req(1'b1, 1'b1, 32'hABCD_0008, 32'h5555_AAAA);
      wait_mem(1'b0, ok);
      checks++; if (!ok || m_addr !== 32'hABCD_0000) begin errors++; $display("FAIL rw_fill_addr got=%h exp=abcd0000", m_addr); end
      ack(LINE_D);
      wait_idle(n);
      checks++; if (p_r_data !== 32'hB0B0_0001) begin errors++; $display("FAIL rw_p_r_hold got=%h exp=b0b00001", p_r_data); end
      wr0 = wr_cnt;
      start_req(1'b1, 1'b0, 32'h1111_1000, '0);
      wait_mem(1'b0, ok);
      ack(LINE_C);
      wait_idle(n);
      checks++; if (!ok || wr_cnt != wr0) begin errors++; $display("FAIL rw_clean_evict got=%0d writes exp=0", wr_cnt - wr0); end
      start_req(1'b1, 1'b0, 32'h2AF3_4000, '0);
      wait_mem(1'b1, ok);
      checks++; if (!ok || m_addr !== 32'hABCD_0000) begin errors++; $display("FAIL rw_dirty_wb_addr got=%h exp=abcd0000", m_addr); end
      checks++; if (m_w_data !== LINE_DW) begin errors++; $display("FAIL rw_dirty_wb_data got=%h exp=%h", m_w_data, LINE_DW); end
   endtask

   task automatic test_reset_mid_transfer;
      bit ok; int n; int wr0;
      checks++; if (mem_write !== 1'b1) begin errors++; $display("FAIL rst_mid_precond got=%b exp=1", mem_write); end
      rst_n = 1'b0;
      #1;
      checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL rst_mid_mem_write got=%b exp=0", mem_write); end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_mid_stall got=%b exp=0", stall); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      wr0 = wr_cnt;
      start_req(1'b1, 1'b0, 32'hABCD_0000, '0);
      wait_mem(1'b0, ok);
      checks++; if (!ok || m_addr !== 32'hABCD_0000) begin errors++; $display("FAIL rst_mid_miss_addr got=%h exp=abcd0000", m_addr); end
      ack(LINE_A);
      wait_idle(n);
      checks++; if (wr_cnt != wr0) begin errors++; $display("FAIL rst_mid_no_write got=%0d exp=0", wr_cnt - wr0); end
      checks++; if (p_r_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rst_mid_data got=%h exp=deadbeef", p_r_data); end
   endtask

`ifdef CACHE_FLUSH_EN
   task automatic test_flush;
      bit ok; int n;
      start_req(1'b0, 1'b1, 32'hABCD_0000, 32'hF00D_0000);
      wait_idle(n);
      start_req(1'b0, 1'b1, 32'hABCD_0FF0, 32'hF00D_0FF0);
      wait_mem(1'b0, ok);
      ack({32'hE0E0_0004, 32'hE0E0_0003, 32'hE0E0_0002, 32'hE0E0_0001});
      wait_idle(n);
      @(negedge clk); cache_flush = 1'b1;
      @(negedge clk); cache_flush = 1'b0;
      wait_mem(1'b1, ok);
      checks++; if (!ok || m_addr !== 32'hABCD_0000) begin errors++; $display("FAIL flush_wb0_addr got=%h exp=abcd0000", m_addr); end
      checks++; if (m_w_data !== {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'hF00D_0000}) begin errors++; $display("FAIL flush_wb0_data got=%h", m_w_data); end
      ack('0);
      wait_mem(1'b1, ok);
      checks++; if (!ok || m_addr !== 32'hABCD_0FF0) begin errors++; $display("FAIL flush_wb1_addr got=%h exp=abcd0ff0", m_addr); end
      checks++; if (m_w_data !== {32'hE0E0_0004, 32'hE0E0_0003, 32'hE0E0_0002, 32'hF00D_0FF0}) begin errors++; $display("FAIL flush_wb1_data got=%h", m_w_data); end
      ack('0);
      wait_idle(n);
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_done got=%b exp=0", stall); end
      start_req(1'b1, 1'b0, 32'hABCD_0000, '0);
      wait_mem(1'b0, ok);
      checks++; if (!ok || m_addr !== 32'hABCD_0000) begin errors++; $display("FAIL flush_then_miss got=%h exp=abcd0000", m_addr); end
      ack(LINE_A);
      wait_idle(n);
   endtask
`endif

   initial begin
      test_reset();
      test_read_miss();
      test_write_hit();
      test_lru_evict();
      test_rw_priority();
      test_reset_mid_transfer();
`ifdef CACHE_FLUSH_EN
      test_flush();
`endif
      checks++; if (both_cnt != 0) begin errors++; $display("FAIL rd_wr_exclusive got=%0d exp=0 overlap cycles", both_cnt); end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/assoc_cache_controller.md
ASSOC_CACHE_CONTROLLER -- requirements
Module: assoc_cache_controller

Interface
REQ-001 SHALL have parameter DATA_W, default 32, processor word width in bits.
REQ-002 SHALL have parameter WORDS_PER_LINE, default 4, words per line (power of 2, >=2).
REQ-003 SHALL have parameter NUM_SETS, default 256, sets per way (power of 2).
REQ-004 SHALL have parameter ADDR_W, default 32, byte address width.
REQ-005 SHALL have ports: clk in 1 clock; rst_n in 1 reset, asynchronous, active-low; one clock only.
REQ-006 SHALL have ports: read_req in 1; write_req in 1; cache_flush in 1; p_addr in ADDR_W; p_w_data in DATA_W; p_r_data out DATA_W; stall out 1.
REQ-007 SHALL have ports: m_addr out ADDR_W; m_w_data out LINE_W; m_r_data in LINE_W; mem_read out 1; mem_write out 1; main_mem_ack in 1. LINE_W = DATA_W*WORDS_PER_LINE.

Function
REQ-008 SHALL be 2-way set-associative, write-back, write-allocate; per line: valid, dirty, tag, data; per set: one LRU bit naming the least-recently-used way.
REQ-009 SHALL split p_addr: byte offset log2(DATA_W/8) bits, word offset log2(WORDS_PER_LINE) bits, index log2(NUM_SETS) bits, tag = remaining upper bits.
REQ-010 SHALL implement states IDLE, COMPARE, WRITE_BACK, ALLOCATE, FLUSH.
REQ-011 IDLE: stall=0; on cache_flush (when enabled) go FLUSH, else on write_req or read_req latch p_addr/p_w_data, go COMPARE; cache_flush > write_req > read_req.
REQ-012 stall SHALL be 1 in every state except IDLE; requests arriving outside IDLE are ignored.
REQ-013 COMPARE hit: read updates p_r_data with the addressed word; write updates that word and sets dirty; LRU points to other way; return IDLE (hit = exactly one stall cycle).
REQ-014 COMPARE miss: victim = first invalid way (way 0 before way 1), else LRU way; go WRITE_BACK if victim valid and dirty, else ALLOCATE.
REQ-015 WRITE_BACK: mem_write=1, m_addr = {victim tag, index, zeros}, m_w_data = victim line, held until main_mem_ack sampled 1; then go ALLOCATE.
REQ-016 ALLOCATE: mem_read=1, m_addr = line-aligned latched address, held until main_mem_ack sampled 1; capture m_r_data that cycle, set tag, valid=1, dirty=0; go COMPARE (request then completes as a hit).
REQ-017 mem_read and mem_write SHALL never be 1 simultaneously; main_mem_ack outside WRITE_BACK/ALLOCATE/FLUSH is ignored.
REQ-018 Requestor SHALL deassert its request the cycle after stall falls; a request still high in IDLE is re-executed.
REQ-019 p_r_data SHALL hold its last value until the next read hit.

Reset
REQ-020 rst_n low SHALL asynchronously force IDLE, stall=0, mem_read=0, mem_write=0, p_r_data=0, m_addr=0, m_w_data=0, and clear all valid, dirty and LRU bits; data and tag arrays are not reset.
REQ-021 Reset mid-transfer SHALL abandon it with no partial line update; first request after release misses.

Configuration
REQ-022 Macro CACHE_FLUSH_EN defined: cache_flush in IDLE enters FLUSH, which walks sets 0..NUM_SETS-1, way 0 then way 1, writing back each valid dirty line with the REQ-015 handshake, then clears all valid/dirty/LRU bits and returns IDLE; stall=1 throughout.
REQ-023 Macro CACHE_FLUSH_EN undefined: cache_flush port present but ignored; FLUSH state and walk counter not built.

Verification (default parameters: index = p_addr[11:4], tag = p_addr[31:12])
REQ-024 After reset, read 0xABCD_0000 -> mem_read=1, m_addr=0xABCD_0000; ack with m_r_data word0=0xDEAD_BEEF -> p_r_data=0xDEAD_BEEF, stall falls, no mem_write.
REQ-025 Write 0xABCD_0004 data 0x1234_5678 after that fill -> one stall cycle, no memory traffic; subsequent read 0xABCD_0004 returns 0x1234_5678.
REQ-026 Dirty 0xABCD_0000 (way 0), fill 0x2AF3_4000 (way 1), read 0xABCD_0000, then read 0x1111_1000 -> victim way 1 clean, mem_read only; then read 0x2AF3_4000 -> mem_write m_addr=0xABCD_0000 with dirty line, then mem_read 0x2AF3_4000.
REQ-027 read_req and write_req both 1 in IDLE on 0xABCD_0008 data 0x5555_AAAA -> write performed, dirty set, p_r_data unchanged.
REQ-028 CACHE_FLUSH_EN: dirty lines at 0xABCD_0000 and 0xABCD_0FF0, pulse cache_flush -> write-backs to 0xABCD_0000 then 0xABCD_0FF0 in order, then read 0xABCD_0000 misses.
REQ-029 rst_n low while mem_write=1 awaiting ack -> mem_write and stall drop immediately; after release read 0xABCD_0000 misses with mem_read only.
